gpio_irq_device: RTL and testbench



---
 rtl/gpio_regs.sv | 28 ++
 rtl/gpio_irq_detect.sv | 33 +++
 rtl/gpio_irq_device.sv | 193 +++++++++++++++++++
 tb/tb_gpio_irq_device.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_regs.sv
// Register offsets, interrupt encodings and defaults shared by the GPIO interrupt device.
package gpio_regs;

  localparam int IN_SYNC = 2;

  localparam logic [11:0] OFF_OE         = 12'h000;
  localparam logic [11:0] OFF_OUT        = 12'h004;
  localparam logic [11:0] OFF_OUT_SET    = 12'h008;
  localparam logic [11:0] OFF_OUT_CLR    = 12'h00C;
  localparam logic [11:0] OFF_OUT_TGL    = 12'h010;
  localparam logic [11:0] OFF_IN         = 12'h014;
  localparam logic [11:0] OFF_IRQ_EN     = 12'h018;
  localparam logic [11:0] OFF_IRQ_TYPE   = 12'h01C;
  localparam logic [11:0] OFF_IRQ_POL    = 12'h020;
  localparam logic [11:0] OFF_IRQ_STATUS = 12'h024;
  localparam logic [11:0] OFF_DEBOUNCE   = 12'h028;

  localparam logic IRQ_TYPE_LEVEL = 1'b0;
  localparam logic IRQ_TYPE_EDGE  = 1'b1;
  localparam logic IRQ_POL_LOW    = 1'b0;
  localparam logic IRQ_POL_HIGH   = 1'b1;

  // Expands the four byte-lane selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] byte_select);
    return {{8{byte_select[3]}}, {8{byte_select[2]}}, {8{byte_select[1]}}, {8{byte_select[0]}}};
  endfunction

endpackage

// File: rtl/gpio_irq_detect.sv
// Per-pin interrupt condition detector with a sticky, write-1-to-clear status bit.
module gpio_irq_detect
  import gpio_regs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cur,
  input  logic prev,
  input  logic irq_type,
  input  logic irq_pol,
  input  logic w1c,
  output logic status
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    if (irq_type == IRQ_TYPE_EDGE)
      hit = (irq_pol == IRQ_POL_HIGH) ? (cur & ~prev) : (~cur & prev);
    else
      hit = (cur == irq_pol);
  end

  // A new hit in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst)
      status <= 1'b0;
    else
      status <= hit | (status & ~w1c);
  end

endmodule

// File: rtl/gpio_irq_device.sv
// GPIO peripheral with atomic output ops and per-pin level/edge interrupts.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_device
  import gpio_regs::*;
#(
  parameter logic [3:0] ID             = 4'h0,
  parameter int         IO_COUNT       = 16,
  parameter int         SYNC_STAGES    = IN_SYNC,
  parameter int         DEBOUNCE_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                peripheralEnable,
  input  logic                peripheralBus_we,
  input  logic                peripheralBus_oe,
  output logic                peripheralBus_busy,
  input  logic [15:0]         peripheralBus_address,
  input  logic [3:0]          peripheralBus_byteSelect,
  output logic [31:0]         peripheralBus_dataRead,
  input  logic [31:0]         peripheralBus_dataWrite,
  output logic                requestOutput,
  input  logic [IO_COUNT-1:0] gpio_input,
  output logic [IO_COUNT-1:0] gpio_output,
  output logic [IO_COUNT-1:0] gpio_oe,
  output logic                gpio_irq
);

  // Device select: the top address nibble carries the device ID.
  logic        device_enable;
  logic [11:0] local_addr;
  logic        wr;
  logic        rd;
  logic [31:0] wmask_full;
  logic [31:0] wdata_full;
  logic [IO_COUNT-1:0] wmask;
  logic [IO_COUNT-1:0] wdata;

  assign device_enable = peripheralEnable & (peripheralBus_address[15:12] == ID);
  assign local_addr    = {peripheralBus_address[11:2], 2'b00};
  assign wr            = device_enable & peripheralBus_we;
  assign rd            = device_enable & peripheralBus_oe;
  assign wmask_full    = lane_mask(peripheralBus_byteSelect);
  assign wdata_full    = peripheralBus_dataWrite & wmask_full;
  assign wmask         = wmask_full[IO_COUNT-1:0];
  assign wdata         = wdata_full[IO_COUNT-1:0];

  logic unused_bits;
  assign unused_bits = &{1'b0, peripheralBus_address[1:0], wdata_full, wmask_full, (DEBOUNCE_WIDTH > 0)};

  logic [IO_COUNT-1:0] oe_reg, out_reg, irq_en_reg, irq_type_reg, irq_pol_reg;
  logic [IO_COUNT-1:0] prev_reg, status, w1c;
  logic [IO_COUNT-1:0] sync_reg [SYNC_STAGES];
  logic [IO_COUNT-1:0] sync, filt;
  logic                irq_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      oe_reg       <= '0;
      out_reg      <= '0;
      irq_en_reg   <= '0;
      irq_type_reg <= '0;
      irq_pol_reg  <= '0;
    end else if (wr) begin
      case (local_addr)
        OFF_OE:       oe_reg       <= (oe_reg & ~wmask) | wdata;
        OFF_OUT:      out_reg      <= (out_reg & ~wmask) | wdata;
        OFF_OUT_SET:  out_reg      <= out_reg | wdata;
        OFF_OUT_CLR:  out_reg      <= out_reg & ~wdata;
        OFF_OUT_TGL:  out_reg      <= out_reg ^ wdata;
        OFF_IRQ_EN:   irq_en_reg   <= (irq_en_reg & ~wmask) | wdata;
        OFF_IRQ_TYPE: irq_type_reg <= (irq_type_reg & ~wmask) | wdata;
        OFF_IRQ_POL:  irq_pol_reg  <= (irq_pol_reg & ~wmask) | wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= gpio_input;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign sync = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [DEBOUNCE_WIDTH-1:0] debounce_reg, prescale_reg;
  logic [IO_COUNT-1:0]       filt_bits;
  logic                      tick;

  assign tick = (prescale_reg == debounce_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      debounce_reg <= '0;
      prescale_reg <= '0;
    end else if (wr && local_addr == OFF_DEBOUNCE) begin
      debounce_reg <= (debounce_reg & ~wmask_full[DEBOUNCE_WIDTH-1:0]) | wdata_full[DEBOUNCE_WIDTH-1:0];
      prescale_reg <= '0;
    end else begin
      prescale_reg <= tick ? '0 : prescale_reg + 1'b1;
    end
  end

  // Each pin accepts a new value once three consecutive ticks agree on it.
  for (genvar gi = 0; gi < IO_COUNT; gi++) begin : g_debounce
    logic       samp_reg, filt_reg;
    logic [1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        samp_reg <= 1'b0;
        filt_reg <= 1'b0;
        cnt_reg  <= 2'd0;
      end else if (tick) begin
        if (sync[gi] == samp_reg) begin
          if (cnt_reg != 2'd3) cnt_reg <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd2) filt_reg <= samp_reg;
        end else begin
          samp_reg <= sync[gi];
          cnt_reg  <= 2'd1;
        end
      end
    end
    assign filt_bits[gi] = filt_reg;
  end

  assign filt = (debounce_reg == '0) ? sync : filt_bits;
`else
  assign filt = sync;
`endif

  assign w1c = (wr && local_addr == OFF_IRQ_STATUS) ? wdata : '0;

  for (genvar gi = 0; gi < IO_COUNT; gi++) begin : g_detect
    gpio_irq_detect u_detect (
      .clk      (clk),
      .rst      (rst),
      .cur      (filt[gi]),
      .prev     (prev_reg[gi]),
      .irq_type (irq_type_reg[gi]),
      .irq_pol  (irq_pol_reg[gi]),
      .w1c      (w1c[gi]),
      .status   (status[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      prev_reg <= filt;
      irq_reg  <= |(status & irq_en_reg);
    end
  end

  logic        read_hit;
  logic [31:0] read_data;

  always_comb begin
    read_hit  = 1'b0;
    read_data = '0;
    if (rd) begin
      case (local_addr)
        OFF_OE:         begin read_hit = 1'b1; read_data = 32'(oe_reg);       end
        OFF_OUT:        begin read_hit = 1'b1; read_data = 32'(out_reg);      end
        OFF_OUT_SET,
        OFF_OUT_CLR,
        OFF_OUT_TGL:    begin read_hit = 1'b1; read_data = '0;                end
        OFF_IN:         begin read_hit = 1'b1; read_data = 32'(filt);         end
        OFF_IRQ_EN:     begin read_hit = 1'b1; read_data = 32'(irq_en_reg);   end
        OFF_IRQ_TYPE:   begin read_hit = 1'b1; read_data = 32'(irq_type_reg); end
        OFF_IRQ_POL:    begin read_hit = 1'b1; read_data = 32'(irq_pol_reg);  end
        OFF_IRQ_STATUS: begin read_hit = 1'b1; read_data = 32'(status);       end
`ifdef GPIO_DEBOUNCE_EN
        OFF_DEBOUNCE:   begin read_hit = 1'b1; read_data = 32'(debounce_reg); end
`endif
        default: ;
      endcase
    end
  end

  assign requestOutput          = read_hit;
  assign peripheralBus_dataRead = read_hit ? read_data : 32'hFFFF_FFFF;
  assign peripheralBus_busy     = 1'b0;
  assign gpio_output            = out_reg;
  assign gpio_oe                = oe_reg;
  assign gpio_irq               = irq_reg;

endmodule

// File: tb/tb_gpio_irq_device.sv
// Directed plus randomized bench for gpio_irq_device against a cycle-level behavioural model.
module tb_gpio_irq_device;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe, we, oe;
  logic        busy;
  logic [15:0] address;
  logic [3:0]  bsel;
  logic [31:0] rdata, wdata;
  logic        req;
  logic [15:0] gpio_input, gpio_output, gpio_oe;
  logic        gpio_irq;

  always #5 clk = ~clk;

  gpio_irq_device #(.ID(4'h0), .IO_COUNT(16), .SYNC_STAGES(S), .DEBOUNCE_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .peripheralEnable(pe), .peripheralBus_we(we), .peripheralBus_oe(oe),
    .peripheralBus_busy(busy), .peripheralBus_address(address),
    .peripheralBus_byteSelect(bsel), .peripheralBus_dataRead(rdata),
    .peripheralBus_dataWrite(wdata), .requestOutput(req),
    .gpio_input(gpio_input), .gpio_output(gpio_output), .gpio_oe(gpio_oe),
    .gpio_irq(gpio_irq)
  );

  int n_vec = 0;
  int n_err = 0;
  bit model_on = 1'b1;

  // Model state: registers plus the pad samples of the last S+1 clock edges.
  logic [15:0] m_oe, m_out, m_en, m_type, m_pol, m_status, m_deb;
  logic        m_irq;
  logic [15:0] hist [S+1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] m_read(input logic [15:0] a);
    logic [11:0] off;
    off = {a[11:2], 2'b00};
    if (a[15:12] != 4'h0) return {1'b0, 32'hFFFF_FFFF};
    case (off)
      12'h000: return {17'h10000, m_oe};
      12'h004: return {17'h10000, m_out};
      12'h008, 12'h00C, 12'h010: return {1'b1, 32'h0};
      12'h014: return {17'h10000, hist[S-1]};
      12'h018: return {17'h10000, m_en};
      12'h01C: return {17'h10000, m_type};
      12'h020: return {17'h10000, m_pol};
      12'h024: return {17'h10000, m_status};
`ifdef GPIO_DEBOUNCE_EN
      12'h028: return {17'h10000, m_deb};
`endif
      default: return {1'b0, 32'hFFFF_FFFF};
    endcase
  endfunction

  // Advance one clock: the model consumes the inputs the DUT sees at this edge.
  task automatic tick();
    logic [15:0] cur, prv, cond, lm, wd, w1c;
    logic [11:0] off;
    logic        dev_wr;
    cur = hist[S-1];
    prv = hist[S];
    for (int p = 0; p < 16; p++) begin
      if (m_type[p]) cond[p] = m_pol[p] ? (cur[p] && !prv[p]) : (!cur[p] && prv[p]);
      else           cond[p] = (cur[p] == m_pol[p]);
    end
    lm     = {{8{bsel[1]}}, {8{bsel[0]}}};
    wd     = wdata[15:0] & lm;
    off    = {address[11:2], 2'b00};
    dev_wr = pe && we && (address[15:12] == 4'h0);
    w1c    = (dev_wr && off == 12'h024) ? wd : 16'h0;
    if (rst) begin
      {m_oe, m_out, m_en, m_type, m_pol, m_status, m_deb} = '0;
      m_irq = 1'b0;
      for (int k = 0; k <= S; k++) hist[k] = '0;
    end else begin
      m_irq    = |(m_status & m_en);
      m_status = cond | (m_status & ~w1c);
      if (dev_wr) begin
        case (off)
          12'h000: m_oe   = (m_oe & ~lm) | wd;
          12'h004: m_out  = (m_out & ~lm) | wd;
          12'h008: m_out  = m_out | wd;
          12'h00C: m_out  = m_out & ~wd;
          12'h010: m_out  = m_out ^ wd;
          12'h018: m_en   = (m_en & ~lm) | wd;
          12'h01C: m_type = (m_type & ~lm) | wd;
          12'h020: m_pol  = (m_pol & ~lm) | wd;
`ifdef GPIO_DEBOUNCE_EN
          12'h028: m_deb  = (m_deb & ~lm) | wd;
`endif
          default: ;
        endcase
      end
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = gpio_input;
    end
    @(posedge clk);
    #1;
    if (model_on) begin
      check("irq", 32'(gpio_irq), 32'(m_irq));
      check("out", 32'(gpio_output), 32'(m_out));
      check("oe", 32'(gpio_oe), 32'(m_oe));
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
    pe = 1'b1; we = 1'b1; oe = 1'b0; address = a; wdata = d; bsel = b;
    tick();
    pe = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    logic [32:0] e;
    pe = 1'b1; oe = 1'b1; we = 1'b0; address = a;
    #1;
    e = m_read(a);
    check($sformatf("req@%h", a), 32'(req), 32'(e[32]));
    check($sformatf("rd@%h", a), rdata, e[31:0]);
    d = rdata;
    tick();
    pe = 1'b0; oe = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int n;
    logic [11:0] offs [10] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                               12'h014, 12'h018, 12'h01C, 12'h020, 12'h024};
    rst = 1'b1; pe = 1'b0; we = 1'b0; oe = 1'b0;
    address = '0; bsel = 4'hF; wdata = '0; gpio_input = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values, then every offset including an unmapped one.
    rd(16'h0024, d);
    check("status_after_reset", d, 32'h0);
    for (int a = 0; a <= 16'h2C; a += 4) rd(16'(a), d);
    check("busy", 32'(busy), 32'h0);
    rd(16'h002C, d);
    check("unmapped_req", 32'(req), 32'h0);
    check("unmapped_data", d, 32'hFFFF_FFFF);

    // Atomic output operations.
    wr(16'h0004, 32'h0000_00F0, 4'hF);
    wr(16'h0008, 32'h0000_0003, 4'hF);
    wr(16'h000C, 32'h0000_0010, 4'hF);
    wr(16'h0010, 32'h0000_8001, 4'hF);
    check("out_ops", 32'(gpio_output), 32'h80E2);
    rd(16'h0008, d); rd(16'h000C, d); rd(16'h0010, d);

    // Byte lanes and foreign ID / disabled accesses.
    wr(16'h0000, 32'h0000_FFFF, 4'b0001);
    check("oe_lane", 32'(gpio_oe), 32'h00FF);
    wr(16'h1004, 32'h0000_FFFF, 4'hF);
    check("foreign_id_write", 32'(gpio_output), 32'h80E2);
    rd(16'h1014, d);
    pe = 1'b0; oe = 1'b1; address = 16'h0014; #1;
    check("no_enable_req", 32'(req), 32'h0);
    oe = 1'b0;

    // Rising edge on pin 0: irq exactly S+2 cycles after the pad change.
    wr(16'h0018, 32'h1, 4'hF);
    wr(16'h001C, 32'h1, 4'hF);
    wr(16'h0020, 32'h1, 4'hF);
    wr(16'h0024, 32'hFFFF, 4'hF);
    tick(); tick();
    check("irq_idle", 32'(gpio_irq), 32'h0);
    gpio_input[0] = 1'b1;
    n = 0;
    while (gpio_irq !== 1'b1 && n < 10) begin tick(); n++; end
    check("edge_latency", n, S + 2);
    rd(16'h0024, d);
    check("edge_status", d & 32'h1, 32'h1);
    wr(16'h0024, 32'h1, 4'hF);
    tick();
    check("irq_cleared", 32'(gpio_irq), 32'h0);

    // Edge set in the same cycle as W1C: set wins.
    gpio_input[0] = 1'b0;
    repeat (4) tick();
    gpio_input[0] = 1'b1;
    tick(); tick();
    wr(16'h0024, 32'h1, 4'hF);
    rd(16'h0024, d);
    check("set_beats_clear", d & 32'h1, 32'h1);

    // Level-low on pin 5 is re-asserted until the pin goes high.
    wr(16'h0024, 32'h1, 4'hF);
    wr(16'h0018, 32'h20, 4'hF);
    wr(16'h0024, 32'h20, 4'hF);
    rd(16'h0024, d);
    check("level_held", d & 32'h20, 32'h20);
    gpio_input[5] = 1'b1;
    repeat (4) tick();
    wr(16'h0024, 32'h20, 4'hF);
    rd(16'h0024, d);
    check("level_released", d & 32'h20, 32'h0);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) gpio_input = 16'($urandom);
      rst = (i == 200);
      case ($urandom_range(0, 2))
        0: tick();
        1: begin
          address = {($urandom_range(0, 7) == 0) ? 4'h1 : 4'h0, offs[$urandom_range(0, 9)]}
                    | 16'($urandom_range(0, 3));
          pe = ($urandom_range(0, 9) != 0); we = 1'b1; oe = 1'b0;
          wdata = $urandom; bsel = 4'($urandom);
          tick();
          pe = 1'b0; we = 1'b0;
        end
        default: rd({($urandom_range(0, 7) == 0) ? 4'h1 : 4'h0, 12'($urandom_range(0, 11) * 4)}, d);
      endcase
      rst = 1'b0;
    end

`ifdef GPIO_DEBOUNCE_EN
    // Debounce period 3: a 5-cycle glitch is rejected, a held level gets through.
    model_on = 1'b0;
    gpio_input = '0;
    wr(16'h0028, 32'h3, 4'hF);
    repeat (30) tick();
    pe = 1'b1; oe = 1'b1; address = 16'h0014;
    gpio_input[1] = 1'b1;
    repeat (5) tick();
    gpio_input[1] = 1'b0;
    d = 0;
    repeat (25) begin tick(); d |= rdata; end
    check("glitch_rejected", d & 32'h2, 32'h0);
    gpio_input[1] = 1'b1;
    repeat (15) tick();
    check("level_accepted", rdata & 32'h2, 32'h2);
    pe = 1'b0; oe = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
